riscv_mc_ctrl: RTL and testbench
================================

Name: riscv_mc_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It replaces single-cycle control for the multi-cycle build, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the PC, IR, register-file, ALU-mux and memory-port enables, and handles a req/ready handshake to the shared instruction/data memory. It supports the same opcode subset as the existing control unit (OP-IMM, LOAD, OP, JAL, STORE, LUI, BRANCH) and traps on anything else.

Parameters:
MEM_TIMEOUT, 16, cycles mem_req may stay unacknowledged before a bus-timeout trap (0 = watchdog disabled)
TO_W, 5, width of watchdog counter (must hold MEM_TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; enables leaving IDLE
opcode  input  7  instr[6:0] from IR (valid from DECODE onward)
br_cond  input  1  branch comparator result for current instr
mem_ready  input  1  memory accepts/completes current request this cycle
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  write qualifier (STORE in MEM)
addr_sel  output  1  0 = PC, 1 = ALU result drives memory address
ir_we  output  1  load IR from memory read data
pc_we  output  1  update PC
pc_sel  output  1  0 = PC+4, 1 = PC+imm
reg_we  output  1  register-file write
wb_sel  output  2  00 ALU, 01 mem data, 10 PC+4, 11 imm (LUI)
alu_src_b  output  1  0 = rs2, 1 = imm
imm_sel  output  3  000 I, 001 S, 010 B, 011 U, 100 J
retire  output  1  one-cycle pulse on instruction completion
trap  output  1  sticky; controller halted
trap_cause  output  2  01 illegal opcode, 10 bus timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded combinationally from registered state and opcode. No output depends on mem_ready except ir_we, pc_we and retire, as noted below.
- Reset (async, rst_n=0): state=IDLE, watchdog=0, trap=0, trap_cause=00. All outputs 0 in IDLE.
- IDLE -> FETCH when run=1. run is sampled only in IDLE; deasserting run mid-instruction takes effect at the next IDLE.
- FETCH: mem_req=1, addr_sel=0.
  - When mem_ready=1: ir_we=1, pc_we=1 (pc_sel=0), and the state goes to DECODE.
  - Otherwise remain in FETCH with all controls stable.
- DECODE: the opcode is classified and imm_sel is driven per opcode. Next state:
  - LUI -> WB
  - OP-IMM, OP, LOAD, STORE, BRANCH, JAL -> EXEC
  - any other opcode -> TRAP with cause 01
- EXEC:
  - alu_src_b=0 for OP/BRANCH, 1 otherwise.
  - BRANCH: pc_we=br_cond, pc_sel=1, retire=1, -> FETCH (or IDLE if run=0).
  - JAL: reg_we=1, wb_sel=10, pc_we=1, pc_sel=1, retire=1, -> FETCH/IDLE. The PC+4 link value is the value latched before the update.
  - LOAD/STORE -> MEM.
  - OP/OP-IMM -> WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - On mem_ready: LOAD -> WB; STORE asserts retire and goes to FETCH/IDLE.
- WB: reg_we=1, wb_sel=01 (LOAD), 11 (LUI), 00 (OP/OP-IMM), retire=1, -> FETCH/IDLE.
- Return target after completion: FETCH if run=1, else IDLE.
- Latency with mem_ready tied high: BRANCH/JAL/LUI 3 cycles, OP/OP-IMM/STORE 4, LOAD 5. Each extra mem_ready-low cycle adds one.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ready=0, and clears on handshake or on leaving FETCH/MEM.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT-1 with mem_ready still 0, go to TRAP with cause 10. mem_req drops on entry to TRAP.
  - A mem_ready arriving in the same cycle as the timeout threshold wins: the handshake completes and there is no trap.
- TRAP: trap=1, all other outputs 0. Held until rst_n.
- Reset mid-operation: immediate return to IDLE, with mem_req deasserted asynchronously.
- imm_sel and alu_src_b are held stable across all cycles of an instruction once the opcode is known, so that a multi-cycle ALU sees stable operands.

Decomposition:
- Shared package riscv_pkg:
  - opcode localparams (OP_IMM 7'b0010011, LOAD 7'b0000011, OP 7'b0110011, JAL 7'b1101111, STORE 7'b0100011, LUI 7'b0110111, BRANCH 7'b1100011)
  - IMM_* and WB_* encodings
  - state encoding
  - trap cause codes
- One sub-module, riscv_opc_class: combinational opcode -> {class, imm_sel, alu_src_b, legal}. The same decoder is reused by the pipelined variant.

Test Plan:
- Reset with run=1, mem_ready=1, OP opcode 7'b0110011 -> FETCH,DECODE,EXEC,WB; retire pulse in cycle 4, reg_we=1 only in WB, wb_sel=00, alu_src_b=0.
- LOAD with mem_ready low for 3 cycles in MEM -> mem_req, addr_sel=1 stable for 4 MEM cycles; WB wb_sel=01; total 8 cycles to retire.
- BRANCH with br_cond=0, then br_cond=1 -> pc_we 0/1 in EXEC, pc_sel=1, retire in cycle 3 both times.
- Opcode 7'b1110011 -> TRAP after DECODE, trap=1, cause=01, no reg_we/mem_we ever; persists until rst_n pulse, then IDLE.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP cause=10 after 4 req cycles. Repeat with mem_ready=1 on the 4th cycle -> no trap, DECODE follows.
- Assert rst_n=0 mid-STORE MEM phase -> mem_req/mem_we drop immediately, state IDLE, no retire.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: opcodes, mux encodings, sequencer states and trap causes.
// Used by both the multi-cycle sequencer and the pipelined control.
package riscv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS_TO  = 2'b10;

    typedef enum logic [2:0] {
        CLS_ILL, CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI
    } opc_class_e;

endpackage

// File: rtl/riscv_opc_class.sv
// Combinational opcode classifier: instruction class, immediate format and ALU B-operand select.
module riscv_opc_class
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output opc_class_e cls,
    output logic [2:0] imm_sel,
    output logic       alu_src_b,
    output logic       legal
);

    always_comb begin
        cls       = CLS_ILL;
        imm_sel   = IMM_I;
        alu_src_b = 1'b1;
        legal     = 1'b1;
        case (opcode)
            OP:      begin cls = CLS_OP;     alu_src_b = 1'b0; end
            OP_IMM:  cls = CLS_OPIMM;
            LOAD:    cls = CLS_LOAD;
            STORE:   begin cls = CLS_STORE;  imm_sel = IMM_S; end
            BRANCH:  begin cls = CLS_BRANCH; imm_sel = IMM_B; alu_src_b = 1'b0; end
            JAL:     begin cls = CLS_JAL;    imm_sel = IMM_J; end
            LUI:     begin cls = CLS_LUI;    imm_sel = IMM_U; end
            default: begin legal = 1'b0;     alu_src_b = 1'b0; end
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared-memory req/ready
// handshake, a bus watchdog and a sticky trap state.
module riscv_mc_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       br_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] imm_sel,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    logic [2:0]      state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [TO_W-1:0] wd_q, wd_d;

    opc_class_e cls;
    logic [2:0] dec_imm;
    logic       dec_asrc;
    logic       dec_legal;

    riscv_opc_class u_opc_class (
        .opcode    (opcode),
        .cls       (cls),
        .imm_sel   (dec_imm),
        .alu_src_b (dec_asrc),
        .legal     (dec_legal)
    );

    logic       req_phase;
    logic       wd_expire;
    logic       op_known;
    logic [2:0] done_state;

    assign req_phase  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign op_known   = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                        (state_q == ST_MEM)    || (state_q == ST_WB);
    assign done_state = run ? ST_FETCH : ST_IDLE;
    // Threshold is one below MEM_TIMEOUT so the trap lands after exactly MEM_TIMEOUT stalled cycles.
    assign wd_expire  = (MEM_TIMEOUT != 0) && req_phase && !mem_ready &&
                        (wd_q == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        wd_d = '0;
        if (MEM_TIMEOUT != 0 && req_phase && !mem_ready) wd_d = wd_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        retire     = 1'b0;
        trap       = 1'b0;
        // Held for the whole instruction so a multi-cycle ALU sees stable operands.
        imm_sel    = op_known ? dec_imm  : IMM_I;
        alu_src_b  = op_known ? dec_asrc : 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS_TO;
                end
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (cls == CLS_LUI) state_d = ST_WB;
                else                         state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_BRANCH: begin
                        pc_we   = br_cond;
                        pc_sel  = 1'b1;
                        retire  = 1'b1;
                        state_d = done_state;
                    end
                    CLS_JAL: begin
                        reg_we  = 1'b1;
                        wb_sel  = WB_PC4;
                        pc_we   = 1'b1;
                        pc_sel  = 1'b1;
                        retire  = 1'b1;
                        state_d = done_state;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        retire  = 1'b1;
                        state_d = done_state;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expire) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS_TO;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (cls == CLS_LOAD) ? WB_MEM : (cls == CLS_LUI) ? WB_IMM : WB_ALU;
                retire  = 1'b1;
                state_d = done_state;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: per-cycle stimulus with hand-computed control vectors.
module tb_riscv_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic       br_cond;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, alu_src_b, retire, trap;
    logic [1:0] wb_sel, trap_cause;
    logic [2:0] imm_sel;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .br_cond(br_cond),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .imm_sel(imm_sel), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel, alu_src_b, imm_sel, retire, trap, trap_cause}
    logic [16:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                  alu_src_b, imm_sel, retire, trap, trap_cause};

    localparam logic [6:0] O_OP  = 7'b0110011, O_LD = 7'b0000011, O_ST  = 7'b0100011;
    localparam logic [6:0] O_BR  = 7'b1100011, O_JAL = 7'b1101111, O_LUI = 7'b0110111;
    localparam logic [6:0] O_ILL = 7'b1110011;

    localparam logic [16:0] X_IDLE    = 17'b0_0_0_0_0_0_0_00_0_000_0_0_00;
    localparam logic [16:0] X_FETCH   = 17'b1_0_0_1_1_0_0_00_0_000_0_0_00;
    localparam logic [16:0] X_FWAIT   = 17'b1_0_0_0_0_0_0_00_0_000_0_0_00;
    localparam logic [16:0] X_OP_WB   = 17'b0_0_0_0_0_0_1_00_0_000_1_0_00;
    localparam logic [16:0] X_LD_DE   = 17'b0_0_0_0_0_0_0_00_1_000_0_0_00;
    localparam logic [16:0] X_LD_MEM  = 17'b1_0_1_0_0_0_0_00_1_000_0_0_00;
    localparam logic [16:0] X_LD_WB   = 17'b0_0_0_0_0_0_1_01_1_000_1_0_00;
    localparam logic [16:0] X_BR_DE   = 17'b0_0_0_0_0_0_0_00_0_010_0_0_00;
    localparam logic [16:0] X_BR_NT   = 17'b0_0_0_0_0_1_0_00_0_010_1_0_00;
    localparam logic [16:0] X_BR_T    = 17'b0_0_0_0_1_1_0_00_0_010_1_0_00;
    localparam logic [16:0] X_ILL     = 17'b0_0_0_0_0_0_0_00_0_000_0_1_01;
    localparam logic [16:0] X_TO      = 17'b0_0_0_0_0_0_0_00_0_000_0_1_10;
    localparam logic [16:0] X_JAL_D   = 17'b0_0_0_0_0_0_0_00_1_100_0_0_00;
    localparam logic [16:0] X_JAL_E   = 17'b0_0_0_0_1_1_1_10_1_100_1_0_00;
    localparam logic [16:0] X_LUI_D   = 17'b0_0_0_0_0_0_0_00_1_011_0_0_00;
    localparam logic [16:0] X_LUI_WB  = 17'b0_0_0_0_0_0_1_11_1_011_1_0_00;
    localparam logic [16:0] X_ST_DE   = 17'b0_0_0_0_0_0_0_00_1_001_0_0_00;
    localparam logic [16:0] X_ST_MEM  = 17'b1_1_1_0_0_0_0_00_1_001_0_0_00;
    localparam logic [16:0] X_ST_DONE = 17'b1_1_1_0_0_0_0_00_1_001_1_0_00;

    // One cycle of stimulus plus the control vector expected during that cycle.
    function automatic logic [26:0] c(input logic r, input logic rd, input logic b,
                                      input logic [6:0] o, input logic [16:0] e);
        return {r, rd, b, o, e};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; br_cond = 1'b0; opcode = O_OP;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (obs !== X_IDLE) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs, X_IDLE); end
        rst_n = 1'b1; run = 1'b0;
        #1;
        n_checks++;
        if (obs !== X_IDLE) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, X_IDLE); end
        @(posedge clk); #2;
    endtask

    task automatic test_op();
        logic [26:0] s[$];
        s.push_back(c(1, 1, 0, O_OP, X_IDLE));
        s.push_back(c(1, 1, 0, O_OP, X_FETCH));
        s.push_back(c(1, 1, 0, O_OP, X_IDLE));
        s.push_back(c(1, 1, 0, O_OP, X_IDLE));
        s.push_back(c(0, 1, 0, O_OP, X_OP_WB));
        s.push_back(c(0, 1, 0, O_OP, X_IDLE));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL op cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_load_wait();
        logic [26:0] s[$];
        s.push_back(c(1, 1, 0, O_LD, X_IDLE));
        s.push_back(c(1, 1, 0, O_LD, X_FETCH));
        s.push_back(c(1, 1, 0, O_LD, X_LD_DE));
        s.push_back(c(1, 1, 0, O_LD, X_LD_DE));
        s.push_back(c(1, 0, 0, O_LD, X_LD_MEM));
        s.push_back(c(1, 0, 0, O_LD, X_LD_MEM));
        s.push_back(c(1, 0, 0, O_LD, X_LD_MEM));
        s.push_back(c(1, 1, 0, O_LD, X_LD_MEM));
        s.push_back(c(0, 1, 0, O_LD, X_LD_WB));
        s.push_back(c(0, 1, 0, O_LD, X_IDLE));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL load cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_branch();
        logic [26:0] s[$];
        s.push_back(c(1, 1, 0, O_BR, X_IDLE));
        s.push_back(c(1, 1, 0, O_BR, X_FETCH));
        s.push_back(c(1, 1, 0, O_BR, X_BR_DE));
        s.push_back(c(1, 1, 0, O_BR, X_BR_NT));
        s.push_back(c(1, 1, 1, O_BR, X_FETCH));
        s.push_back(c(1, 1, 1, O_BR, X_BR_DE));
        s.push_back(c(0, 1, 1, O_BR, X_BR_T));
        s.push_back(c(0, 1, 0, O_BR, X_IDLE));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL branch cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_illegal();
        logic [26:0] s[$];
        s.push_back(c(1, 1, 0, O_ILL, X_IDLE));
        s.push_back(c(1, 1, 0, O_ILL, X_FETCH));
        s.push_back(c(1, 1, 0, O_ILL, X_IDLE));
        s.push_back(c(1, 1, 0, O_ILL, X_ILL));
        s.push_back(c(1, 0, 1, O_OP,  X_ILL));
        s.push_back(c(0, 1, 0, O_LD,  X_ILL));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL illegal cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== X_IDLE) begin n_fail++; $display("FAIL illegal_clear: got %b want %b", obs, X_IDLE); end
        @(posedge clk); #2;
        rst_n = 1'b1; run = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if (obs !== X_IDLE) begin n_fail++; $display("FAIL illegal_idle: got %b want %b", obs, X_IDLE); end
    endtask

    task automatic test_timeout();
        logic [26:0] s[$];
        logic [26:0] t[$];
        s.push_back(c(1, 0, 0, O_OP, X_IDLE));
        s.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        s.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        s.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        s.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        s.push_back(c(0, 0, 0, O_OP, X_TO));
        s.push_back(c(1, 1, 0, O_OP, X_TO));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL timeout cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
        rst_n = 1'b0; run = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        t.push_back(c(1, 0, 0, O_OP, X_IDLE));
        t.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        t.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        t.push_back(c(0, 0, 0, O_OP, X_FWAIT));
        t.push_back(c(0, 1, 0, O_OP, X_FETCH));
        t.push_back(c(0, 1, 0, O_OP, X_IDLE));
        t.push_back(c(0, 1, 0, O_OP, X_IDLE));
        t.push_back(c(0, 1, 0, O_OP, X_OP_WB));
        t.push_back(c(0, 1, 0, O_OP, X_IDLE));
        foreach (t[i]) begin
            {run, mem_ready, br_cond, opcode} = t[i][26:17];
            #2;
            n_checks++;
            if (obs !== t[i][16:0]) begin n_fail++; $display("FAIL timeout_tie cyc%0d: got %b want %b", i, obs, t[i][16:0]); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_store_reset();
        logic [26:0] s[$];
        s.push_back(c(1, 1, 0, O_ST, X_IDLE));
        s.push_back(c(1, 1, 0, O_ST, X_FETCH));
        s.push_back(c(1, 1, 0, O_ST, X_ST_DE));
        s.push_back(c(1, 1, 0, O_ST, X_ST_DE));
        s.push_back(c(1, 0, 0, O_ST, X_ST_MEM));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL store_rst cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
        #1;
        n_checks++;
        if (obs !== X_ST_MEM) begin n_fail++; $display("FAIL store_pending: got %b want %b", obs, X_ST_MEM); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== X_IDLE) begin n_fail++; $display("FAIL store_async_drop: got %b want %b", obs, X_IDLE); end
        @(posedge clk); #2;
        rst_n = 1'b1; run = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if (obs !== X_IDLE) begin n_fail++; $display("FAIL store_idle: got %b want %b", obs, X_IDLE); end
    endtask

    task automatic test_back_to_back();
        logic [26:0] s[$];
        s.push_back(c(1, 1, 0, O_JAL, X_IDLE));
        s.push_back(c(1, 1, 0, O_JAL, X_FETCH));
        s.push_back(c(1, 1, 0, O_JAL, X_JAL_D));
        s.push_back(c(1, 1, 0, O_JAL, X_JAL_E));
        s.push_back(c(1, 1, 0, O_JAL, X_FETCH));
        s.push_back(c(1, 1, 0, O_LUI, X_LUI_D));
        s.push_back(c(1, 1, 0, O_LUI, X_LUI_WB));
        s.push_back(c(1, 1, 0, O_LUI, X_FETCH));
        s.push_back(c(1, 1, 0, O_ST,  X_ST_DE));
        s.push_back(c(1, 1, 0, O_ST,  X_ST_DE));
        s.push_back(c(0, 1, 0, O_ST,  X_ST_DONE));
        s.push_back(c(0, 1, 0, O_ST,  X_IDLE));
        foreach (s[i]) begin
            {run, mem_ready, br_cond, opcode} = s[i][26:17];
            #2;
            n_checks++;
            if (obs !== s[i][16:0]) begin n_fail++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs, s[i][16:0]); end
            @(posedge clk); #2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_op();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_store_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
